aes_inv_sub_bytes: RTL and testbench

- Iterative AES InvSubBytes engine: accepts one 128-bit AES state and applies the inverse S-box to all 16 bytes.
- Computes each byte arithmetically, not by table lookup: inverse affine transform, then GF(2^8) multiplicative inverse (x^254, modulus 0x11B) by square-and-multiply.
- Sits in the decryption datapath as the counterpart of the forward registered S-box. Valid/ready on both sides.

---
 rtl/aes_inv_sub_bytes.sv | 160 ++++++++++++++++
 tb/tb_aes_inv_sub_bytes.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_sub_bytes.sv
// Iterative AES InvSubBytes engine: inverse affine, then GF(2^8) x^254 by square-and-multiply, LANES bytes at a time.
// Optional macro AES_SBOX_FWD_MODE_EN adds a 'mode' input selecting the forward S-box (mode=1).
module aes_inv_sub_bytes #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
`ifdef AES_SBOX_FWD_MODE_EN
    input  logic         mode,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("aes_inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam int         G          = 16 / LANES;
    localparam logic [3:0] LAST_GROUP = 4'(G - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] inv_aff(input logic [7:0] s);
        return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
    endfunction

    function automatic logic [7:0] fwd_aff(input logic [7:0] y);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    // Shift-and-add multiply with reduction by x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    state_t       state_q;
    logic [127:0] data_q;
    logic [127:0] res_q;
    logic [127:0] res_next;
    logic [3:0]   group_q;
    logic [2:0]   step_q;
    logic [7:0]   t_q   [LANES];
    logic [7:0]   acc_q [LANES];
    logic [7:0]   sq_d  [LANES];
    logic [7:0]   acc_d [LANES];
    logic         mode_q;

`ifdef AES_SBOX_FWD_MODE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          mode_q <= 1'b0;
        else if (state_q == IDLE && in_valid) mode_q <= mode;
    end
`else
    assign mode_q = 1'b0;
`endif

    // Step 1 squares the freshly transformed byte; later steps square t and fold it into acc.
    always_comb begin
        int         idx;
        logic [7:0] s;
        logic [7:0] x;
        logic [7:0] sq_in;
        idx      = 0;
        s        = 8'h00;
        x        = 8'h00;
        sq_in    = 8'h00;
        res_next = res_q;
        for (int l = 0; l < LANES; l++) begin
            idx      = int'(group_q) * LANES + l;
            s        = data_q[127-8*idx -: 8];
            x        = mode_q ? s : inv_aff(s);
            sq_in    = (step_q == 3'd1) ? x : t_q[l];
            sq_d[l]  = gf_mul(sq_in, sq_in);
            acc_d[l] = (step_q == 3'd1) ? sq_d[l] : gf_mul(acc_q[l], sq_d[l]);
            res_next[127-8*idx -: 8] = mode_q ? fwd_aff(acc_d[l]) : acc_d[l];
        end
    end

    // NOTE: state registers use non-blocking assignments so every update samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            res_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            group_q   <= '0;
            step_q    <= '0;
            for (int l = 0; l < LANES; l++) begin
                t_q[l]   <= 8'h00;
                acc_q[l] <= 8'h00;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        group_q  <= '0;
                        step_q   <= 3'd1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        t_q[l]   <= sq_d[l];
                        acc_q[l] <= acc_d[l];
                    end
                    if (step_q == 3'd7) begin
                        res_q  <= res_next;
                        step_q <= 3'd1;
                        if (group_q == LAST_GROUP) begin
                            out_data  <= res_next;
                            out_valid <= 1'b1;
                            group_q   <= '0;
                            state_q   <= DONE;
                        end else begin
                            group_q <= group_q + 4'd1;
                        end
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Directed self-checking bench for aes_inv_sub_bytes (LANES=4 main instance, LANES=1 and 16 for latency).
// Forward-mode and round-trip checks are compiled in when AES_SBOX_FWD_MODE_EN is defined.
module tb_aes_inv_sub_bytes;

    logic         clk;
    logic         reset;
    logic         mode;
    logic [127:0] in_data;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] out_data;
    logic         in_valid_x, out_ready_x;
    logic         in_ready_1, out_valid_1, busy_1;
    logic         in_ready_16, out_valid_16, busy_16;
    logic [127:0] out_data_1, out_data_16;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [128-1:0] SBOX_0_15 = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [128-1:0] BYTES_0_15 = 128'h000102030405060708090a0b0c0d0e0f;

    aes_inv_sub_bytes #(.LANES(4)) dut (
        .clk(clk), .reset(reset),
`ifdef AES_SBOX_FWD_MODE_EN
        .mode(mode),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    aes_inv_sub_bytes #(.LANES(1)) dut_1 (
        .clk(clk), .reset(reset),
`ifdef AES_SBOX_FWD_MODE_EN
        .mode(mode),
`endif
        .in_valid(in_valid_x), .in_ready(in_ready_1), .in_data(in_data),
        .out_valid(out_valid_1), .out_ready(out_ready_x), .out_data(out_data_1), .busy(busy_1)
    );

    aes_inv_sub_bytes #(.LANES(16)) dut_16 (
        .clk(clk), .reset(reset),
`ifdef AES_SBOX_FWD_MODE_EN
        .mode(mode),
`endif
        .in_valid(in_valid_x), .in_ready(in_ready_16), .in_data(in_data),
        .out_valid(out_valid_16), .out_ready(out_ready_x), .out_data(out_data_16), .busy(busy_16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the LANES=4 instance; lat counts edges from acceptance to out_valid.
    task automatic xfer(input logic [127:0] din, output logic [127:0] dout, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin tick(); w++; end
        in_data  = din;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin tick(); lat++; end
        dout = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] held;
        int           lat, lat1, lat4, lat16;

        reset = 1'b0; mode = 1'b0; in_data = SBOX_0_15; in_valid = 1'b1; out_ready = 1'b0;
        in_valid_x = 1'b1; out_ready_x = 1'b0;

        // Reset with in_valid asserted: nothing must be captured.
        repeat (3) tick();
        check("reset_out_valid", 128'(out_valid), 128'(1'b0));
        check("reset_out_data",  out_data, '0);
        check("reset_in_ready",  128'(in_ready), 128'(1'b1));
        check("reset_busy",      128'(busy), 128'(1'b0));
        in_valid = 1'b0; in_valid_x = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        check("post_reset_in_ready", 128'(in_ready), 128'(1'b1));
        check("post_reset_busy",     128'(busy), 128'(1'b0));

        // Known vector on LANES = 1, 4, 16 concurrently.
        in_data = SBOX_0_15; in_valid = 1'b1; in_valid_x = 1'b1;
        tick();
        in_valid = 1'b0; in_valid_x = 1'b0;
        check("accept_in_ready", 128'(in_ready), 128'(1'b0));
        check("accept_busy",     128'(busy), 128'(1'b1));
        lat1 = -1; lat4 = -1; lat16 = -1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (out_valid    && lat4  < 0) lat4  = c;
            if (out_valid_1  && lat1  < 0) lat1  = c;
            if (out_valid_16 && lat16 < 0) lat16 = c;
            if (lat1 >= 0 && lat4 >= 0 && lat16 >= 0) break;
        end
        check("latency_lanes4",  128'(lat4),  128'(28));
        check("latency_lanes1",  128'(lat1),  128'(112));
        check("latency_lanes16", 128'(lat16), 128'(7));
        check("known_lanes4",  out_data,    BYTES_0_15);
        check("known_lanes1",  out_data_1,  BYTES_0_15);
        check("known_lanes16", out_data_16, BYTES_0_15);
        out_ready = 1'b1; out_ready_x = 1'b1;
        tick();
        out_ready = 1'b0; out_ready_x = 1'b0;
        check("handshake_out_valid", 128'(out_valid), 128'(1'b0));
        check("handshake_in_ready",  128'(in_ready), 128'(1'b1));

        // Edge values.
        xfer({16{8'h16}}, d, lat);
        check("all16_data", d, {16{8'hff}});
        check("all16_lat",  128'(lat), 128'(28));
        xfer({16{8'h63}}, d, lat);
        check("all63_data", d, {16{8'h00}});
        xfer({16{8'h7c}}, d, lat);
        check("all7c_data", d, {16{8'h01}});

        // Backpressure: all 0x00, then hold out_ready low with a competing input pending.
        in_data = {16{8'h00}}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin tick(); lat++; end
        check("all00_lat", 128'(lat), 128'(28));
        held = out_data;
        check("all00_data", held, {16{8'h52}});
        in_data = {16{8'h16}}; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 128'(out_valid), 128'(1'b1));
            check("bp_out_data",  out_data, {16{8'h52}});
            check("bp_in_ready",  128'(in_ready), 128'(1'b0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_out_valid", 128'(out_valid), 128'(1'b0));
        check("bp_release_in_ready",  128'(in_ready), 128'(1'b1));
        check("bp_release_busy",      128'(busy), 128'(1'b0));
        tick();
        in_valid = 1'b0;
        check("bp_next_accepted", 128'(in_ready), 128'(1'b0));
        check("bp_next_hold_data", out_data, {16{8'h52}});
        lat = 0;
        while (!out_valid && lat < 300) begin tick(); lat++; end
        check("bp_next_lat",  128'(lat), 128'(28));
        check("bp_next_data", out_data, {16{8'hff}});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Abort: reset asserted before step 3 of group 1 executes.
        in_data = SBOX_0_15; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("abort_busy_before", 128'(busy), 128'(1'b1));
        reset = 1'b0;
        #1;
        check("abort_out_valid", 128'(out_valid), 128'(1'b0));
        check("abort_in_ready",  128'(in_ready), 128'(1'b1));
        check("abort_busy",      128'(busy), 128'(1'b0));
        check("abort_out_data",  out_data, '0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("abort_idle_out_valid", 128'(out_valid), 128'(1'b0));
        xfer({16{8'h00}}, d, lat);
        check("abort_next_data", d, {16{8'h52}});
        check("abort_next_lat",  128'(lat), 128'(28));

`ifdef AES_SBOX_FWD_MODE_EN
        mode = 1'b1;
        xfer(BYTES_0_15, d, lat);
        check("fwd_known", d, SBOX_0_15);
        check("fwd_lat",   128'(lat), 128'(28));
        xfer({16{8'h00}}, d, lat);
        check("fwd_zero", d, {16{8'h63}});
        for (int k = 0; k < 256; k++) begin
            logic [127:0] s;
            logic [127:0] f;
            logic [127:0] r;
            s = {$urandom(), $urandom(), $urandom(), $urandom()};
            mode = 1'b1;
            xfer(s, f, lat);
            mode = 1'b0;
            xfer(f, r, lat);
            check("round_trip", r, s);
        end
        mode = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
